// File: rtl/gauss_filter_stream.sv
// Streaming KxK symmetric Gaussian filter: line-buffered window, 5-stage MAC pipeline,
// per-frame coefficient latch, border policy and automatic end-of-frame flush.
module gauss_filter_stream #(
    parameter int DATA_W = 8,
    parameter int COE_W  = 8,
    parameter int FRAC   = 8,
    parameter int IMG_W  = 1024,
    parameter int IMG_H  = 1024,
    parameter int KSIZE  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6*COE_W-1:0]   coe_in,
    input  logic                 edge_mode,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_user,
    input  logic                 s_last,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_user,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err
);
    localparam int R      = KSIZE / 2;
    localparam int OFF    = 2 - R;
    localparam int PW     = DATA_W + COE_W;
    localparam int AW     = DATA_W + COE_W + 5;
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H + KSIZE);
    localparam int STAGES = 5;
    localparam logic [AW:0] HALF = (AW+1)'(1) << (FRAC - 1);
    localparam logic [AW:0] MAXV = (AW+1)'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;
    typedef struct packed {
        logic              brd;
        logic              usr;
        logic              lst;
        logic              fin;
        logic [DATA_W-1:0] ctr;
    } side_t;

    state_t             state_q;
    logic [XW-1:0]      in_x_q, ox_q, px;
    logic [YW-1:0]      in_y_q, oy_q, py;
    logic [6*COE_W-1:0] coe_q;
    logic               edge_q, fl_done_q, rdy_en_q, err_q, fin_q;
    logic [STAGES:1]    vld_pipe_q;
    logic [DATA_W-1:0]  m_data_q, pix, sat;
    logic               m_user_q, m_last_q;
    logic               adv, acc_in, restart, inj, beat, produce;
    logic [AW:0]        rnd;

    logic [DATA_W-1:0]  lb_q   [KSIZE-1][IMG_W];
    logic [DATA_W-1:0]  win_q  [KSIZE][KSIZE];
    logic [DATA_W-1:0]  col    [KSIZE];
    logic [PW-1:0]      prod_q [KSIZE][KSIZE];
    logic [AW-1:0]      rs_d   [KSIZE];
    logic [AW-1:0]      rs_q   [KSIZE];
    logic [AW-1:0]      tot_d, tot_q;
    side_t              side_q [1:STAGES-1];

    // 3x3 kernels use the outer part of the 5x5 table: distance d maps to index d+1.
    function automatic logic [COE_W-1:0] coe_at(input logic [6*COE_W-1:0] c, input int r, input int k);
        int dy, dx, a, b, idx;
        dy  = (r > R) ? r - R : R - r;
        dx  = (k > R) ? k - R : R - k;
        a   = ((dy < dx) ? dy : dx) + OFF;
        b   = ((dy < dx) ? dx : dy) + OFF;
        idx = (a == 0) ? b : (a == 1) ? b + 2 : 5;
        return c[idx*COE_W +: COE_W];
    endfunction

    assign adv     = m_ready | ~vld_pipe_q[STAGES];
    assign s_ready = adv & rdy_en_q & (state_q != ST_FLUSH);
    assign acc_in  = s_valid & s_ready;
    assign restart = acc_in & s_user;
    assign inj     = adv & (state_q == ST_FLUSH) & ~fl_done_q;
    assign beat    = (acc_in & (s_user | (state_q != ST_IDLE))) | inj;
    assign px      = restart ? '0 : in_x_q;
    assign py      = restart ? '0 : in_y_q;
    assign pix     = inj ? '0 : s_data;
    assign produce = beat & ((py > YW'(R)) | ((py == YW'(R)) & (px >= XW'(R))));

    assign m_valid = vld_pipe_q[STAGES];
    assign m_data  = m_data_q;
    assign m_user  = m_user_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

    always_comb begin
        for (int k = 0; k < KSIZE-1; k++) col[k] = lb_q[k][px];
        col[KSIZE-1] = pix;
        for (int r = 0; r < KSIZE; r++) begin
            rs_d[r] = '0;
            for (int k = 0; k < KSIZE; k++) rs_d[r] = rs_d[r] + AW'(prod_q[r][k]);
        end
        tot_d = '0;
        for (int r = 0; r < KSIZE; r++) tot_d = tot_d + rs_q[r];
        rnd = ({1'b0, tot_q} + HALF) >> FRAC;
        sat = (rnd > MAXV) ? '1 : rnd[DATA_W-1:0];
    end

    // Datapath: line buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int k = 0; k < KSIZE-1; k++) lb_q[k][px] <= col[k+1];
            for (int r = 0; r < KSIZE; r++) begin
                for (int k = 0; k < KSIZE-1; k++) win_q[r][k] <= win_q[r][k+1];
                win_q[r][KSIZE-1] <= col[r];
            end
        end
        if (adv) begin
            side_q[1].brd <= (ox_q < XW'(R)) | (ox_q >= XW'(IMG_W-R)) |
                             (oy_q < YW'(R)) | (oy_q >= YW'(IMG_H-R));
            side_q[1].usr <= (ox_q == '0) & (oy_q == '0);
            side_q[1].lst <= (ox_q == XW'(IMG_W-1));
            side_q[1].fin <= (ox_q == XW'(IMG_W-1)) & (oy_q == YW'(IMG_H-1));
            side_q[1].ctr <= '0;
            for (int r = 0; r < KSIZE; r++)
                for (int k = 0; k < KSIZE; k++)
                    prod_q[r][k] <= PW'(win_q[r][k]) * PW'(coe_at(coe_q, r, k));
            side_q[2]     <= side_q[1];
            side_q[2].ctr <= win_q[R][R];
            rs_q          <= rs_d;
            side_q[3]     <= side_q[2];
            tot_q         <= tot_d;
            side_q[4]     <= side_q[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_x_q     <= '0;
            in_y_q     <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            coe_q      <= '0;
            edge_q     <= 1'b0;
            fl_done_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
            vld_pipe_q <= '0;
            m_data_q   <= '0;
            m_user_q   <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (adv) begin
                vld_pipe_q <= {vld_pipe_q[STAGES-1:1], produce};
                if (vld_pipe_q[STAGES-1]) begin
                    m_data_q <= side_q[STAGES-1].brd ? (edge_q ? side_q[STAGES-1].ctr : '0) : sat;
                    m_user_q <= side_q[STAGES-1].usr;
                    m_last_q <= side_q[STAGES-1].lst;
                    fin_q    <= side_q[STAGES-1].fin;
                end
                // A new s_user drops everything in flight; the visible output is being handshaken now.
                if (restart) vld_pipe_q <= '0;
            end
            if (restart) begin
                state_q   <= ST_FILL;
                in_x_q    <= XW'(1);
                in_y_q    <= '0;
                ox_q      <= '0;
                oy_q      <= '0;
                coe_q     <= coe_in;
                edge_q    <= edge_mode;
                fl_done_q <= 1'b0;
                if (state_q != ST_IDLE || s_last) err_q <= 1'b1;
            end else begin
                if (acc_in && state_q == ST_IDLE) err_q <= 1'b1;
                if (acc_in && s_last && px != XW'(IMG_W-1)) err_q <= 1'b1;
                if (beat) begin
                    in_x_q <= (px == XW'(IMG_W-1)) ? '0 : px + 1'b1;
                    if (px == XW'(IMG_W-1)) in_y_q <= py + 1'b1;
                    if (acc_in && px == XW'(IMG_W-1) && py == YW'(IMG_H-1)) state_q <= ST_FLUSH;
                    else if (produce && state_q == ST_FILL) state_q <= ST_RUN;
                end
                if (produce) begin
                    ox_q <= (ox_q == XW'(IMG_W-1)) ? '0 : ox_q + 1'b1;
                    if (ox_q == XW'(IMG_W-1)) oy_q <= oy_q + 1'b1;
                    if (ox_q == XW'(IMG_W-1) && oy_q == YW'(IMG_H-1)) fl_done_q <= 1'b1;
                end
                if (state_q == ST_FLUSH && vld_pipe_q[STAGES] && m_ready && fin_q) state_q <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_gauss_filter_stream.sv
// Randomised bench for gauss_filter_stream (8x6 frames, 5x5 and 3x3 instances) against a
// direct-convolution reference model.
module tb_gauss_filter_stream;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] coe_in = '0;
    logic        edge_mode = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic        sel = 1'b0;

    logic        s_ready5, m_valid5, m_user5, m_last5, busy5, err5;
    logic        s_ready3, m_valid3, m_user3, m_last3, busy3, err3;
    logic [7:0]  m_data5, m_data3;
    logic        s_ready_w, m_valid_w, m_user_w, m_last_w, busy_w, err_w;
    logic [7:0]  m_data_w;

    always #5 clk = ~clk;

    gauss_filter_stream #(.DATA_W(8), .COE_W(8), .FRAC(8), .IMG_W(W), .IMG_H(H), .KSIZE(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .coe_in(coe_in), .edge_mode(edge_mode),
        .s_data(s_data), .s_valid(s_valid & ~sel), .s_ready(s_ready5), .s_user(s_user), .s_last(s_last),
        .m_data(m_data5), .m_valid(m_valid5), .m_ready(m_ready), .m_user(m_user5), .m_last(m_last5),
        .busy(busy5), .err(err5));

    gauss_filter_stream #(.DATA_W(8), .COE_W(8), .FRAC(8), .IMG_W(W), .IMG_H(H), .KSIZE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .coe_in(coe_in), .edge_mode(edge_mode),
        .s_data(s_data), .s_valid(s_valid & sel), .s_ready(s_ready3), .s_user(s_user), .s_last(s_last),
        .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready), .m_user(m_user3), .m_last(m_last3),
        .busy(busy3), .err(err3));

    assign s_ready_w = sel ? s_ready3 : s_ready5;
    assign m_valid_w = sel ? m_valid3 : m_valid5;
    assign m_data_w  = sel ? m_data3  : m_data5;
    assign m_user_w  = sel ? m_user3  : m_user5;
    assign m_last_w  = sel ? m_last3  : m_last5;
    assign busy_w    = sel ? busy3    : busy5;
    assign err_w     = sel ? err3     : err5;

    typedef struct { int d; bit u; bit l; } out_t;
    out_t expq[$];
    int   img [H][W];
    int   cm  [3][3];
    int   em, kk = 5;
    int   n_cmp = 0, n_bad = 0;
    bit   stall_prev = 0;
    logic [7:0] hold_d;
    logic hold_u, hold_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int coef(input int dy, input int dx);
        int a, b, off;
        a   = (dy < 0) ? -dy : dy;
        b   = (dx < 0) ? -dx : dx;
        off = 2 - kk / 2;
        return (a < b) ? cm[a+off][b+off] : cm[b+off][a+off];
    endfunction

    // Expected value of each output pixel in raster order, first nout of the frame.
    task automatic push_ref(input int nout);
        int r;
        r = kk / 2;
        for (int i = 0; i < nout; i++) begin
            int y, x, v;
            longint acc;
            out_t o;
            y = i / W;
            x = i % W;
            if (y < r || y >= H - r || x < r || x >= W - r) v = em ? img[y][x] : 0;
            else begin
                acc = 0;
                for (int dy = -r; dy <= r; dy++)
                    for (int dx = -r; dx <= r; dx++)
                        acc += longint'(img[y+dy][x+dx]) * coef(dy, dx);
                v = int'((acc + 128) / 256);
                if (v > 255) v = 255;
            end
            o.d = v; o.u = (i == 0); o.l = (x == W - 1);
            expq.push_back(o);
        end
    endtask

    task automatic set_coe();
        coe_in    = {8'(cm[2][2]), 8'(cm[1][2]), 8'(cm[1][1]), 8'(cm[0][2]), 8'(cm[0][1]), 8'(cm[0][0])};
        edge_mode = em[0];
    endtask

    // Inputs for this cycle are already applied; sample, score, then move to the next negedge.
    task automatic step(output bit acc);
        out_t e;
        #1;
        acc = s_valid && s_ready_w;
        if (stall_prev) begin
            chk("hold_valid", m_valid_w, 1);
            chk("hold_data", m_data_w, hold_d);
            chk("hold_user", m_user_w, hold_u);
            chk("hold_last", m_last_w, hold_l);
        end
        if (m_valid_w && m_ready) begin
            if (expq.size() == 0) chk("extra_output", 1, 0);
            else begin
                e = expq.pop_front();
                chk("data", m_data_w, e.d);
                chk("user", m_user_w, e.u);
                chk("last", m_last_w, e.l);
            end
        end
        stall_prev = m_valid_w && !m_ready;
        hold_d = m_data_w; hold_u = m_user_w; hold_l = m_last_w;
        @(negedge clk);
    endtask

    task automatic send_frame(input int npix, input int pv, input int pr, input int bad_y, input int bad_x,
                              output int cyc);
        int p;
        bit a;
        p = 0; cyc = 0;
        while (p < npix && cyc < 5000) begin
            s_valid = ($urandom_range(99) < pv);
            s_data  = 8'(img[p / W][p % W]);
            s_user  = (p == 0);
            s_last  = (p % W == W - 1) || (p / W == bad_y && p % W == bad_x);
            m_ready = ($urandom_range(99) < pr);
            step(a);
            if (a) p++;
            cyc++;
        end
        if (p < npix) chk("send_timeout", p, npix);
        s_valid = 0; s_user = 0; s_last = 0;
    endtask

    task automatic drain(input int pr, output int cyc);
        bit a;
        cyc = 0;
        s_valid = 0;
        while (expq.size() > 0 && cyc < 3000) begin
            m_ready = ($urandom_range(99) < pr);
            step(a);
            cyc++;
        end
        if (expq.size() > 0) chk("drain_timeout", expq.size(), 0);
    endtask

    task automatic idle(input int n);
        bit a;
        s_valid = 0; m_ready = 1;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic run_frame(input int pv, input int pr, input bit tput);
        int c1, c2;
        set_coe();
        push_ref(W * H);
        send_frame(W * H, pv, pr, -1, -1, c1);
        drain(pr, c2);
        if (tput) begin
            chk("fill_tput", c1, W * H);
            chk("flush_tput", c2, (kk / 2) * W + kk / 2 + 5);
        end
        chk("busy_end", busy_w, 0);
        idle(8);
    endtask

    task automatic do_reset();
        s_valid = 0; s_user = 0; s_last = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_s_ready", s_ready_w, 0);
        chk("rst_m_valid", m_valid_w, 0);
        chk("rst_m_data", m_data_w, 0);
        chk("rst_m_user", m_user_w, 0);
        chk("rst_m_last", m_last_w, 0);
        chk("rst_busy", busy_w, 0);
        chk("rst_err", err_w, 0);
        expq.delete();
        stall_prev = 0;
        @(negedge clk); rst_n = 1;
        #1 chk("rst_rdy_low", s_ready_w, 0);
        @(negedge clk);
        #1 chk("rst_rdy_high", s_ready_w, 1);
        @(negedge clk);
    endtask

    task automatic fill_img(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0: img[y][x] = 100;
                    1: img[y][x] = (y == 3 && x == 3) ? 255 : 0;
                    2: img[y][x] = 255;
                    default: img[y][x] = int'($urandom_range(255));
                endcase
    endtask

    task automatic gauss5();
        cm = '{'{36, 24, 6}, '{0, 16, 4}, '{0, 0, 1}};
    endtask

    initial begin
        int c;
        bit a;
        @(negedge clk);
        do_reset();

        gauss5();
        fill_img(0); em = 0; run_frame(100, 100, 1);
        fill_img(0); em = 1; run_frame(100, 100, 1);
        fill_img(1); em = 0; run_frame(100, 100, 0);
        fill_img(2); em = 0; cm = '{'{255, 255, 255}, '{0, 255, 255}, '{0, 0, 255}}; run_frame(100, 100, 0);
        for (int t = 0; t < 3; t++) begin
            fill_img(3); em = int'($urandom_range(1));
            for (int i = 0; i < 3; i++) for (int j = i; j < 3; j++) cm[i][j] = int'($urandom_range(40));
            run_frame(60, 30, 0);
        end

        // Mid-frame restart: 20 beats of frame A give exactly 2 outputs before frame B takes over.
        gauss5(); em = 1; fill_img(3); set_coe();
        push_ref(2);
        send_frame(20, 100, 100, -1, -1, c);
        drain(100, c);
        idle(10);
        chk("busy_partial", busy_w, 1);
        chk("err_before_restart", err_w, 0);
        fill_img(3); run_frame(80, 70, 0);
        chk("err_restart", err_w, 1);
        do_reset();

        // Early s_last on line 1 is flagged but the frame still completes by position.
        fill_img(3); em = 0; set_coe();
        push_ref(W * H);
        send_frame(W * H, 100, 100, 1, 5, c);
        drain(100, c);
        chk("err_last", err_w, 1);
        chk("busy_end_last", busy_w, 0);
        idle(8);

        // Reset in the middle of RUN while outputs are streaming.
        fill_img(0); em = 1; set_coe();
        push_ref(W * H);
        send_frame(30, 100, 100, -1, -1, c);
        #1;
        chk("pre_rst_valid", m_valid_w, 1);
        chk("pre_rst_busy", busy_w, 1);
        do_reset();
        fill_img(3); em = 1; run_frame(100, 100, 1);

        // Stray beat in IDLE without s_user is swallowed and flagged.
        s_valid = 1; s_user = 0; s_data = 8'd77; m_ready = 1;
        step(a);
        chk("stray_accepted", a, 1);
        idle(10);
        chk("err_stray", err_w, 1);
        chk("busy_stray", busy_w, 0);
        do_reset();

        // 3x3 instance.
        sel = 1; kk = 3;
        idle(2);
        cm = '{'{0, 0, 0}, '{0, 64, 32}, '{0, 0, 16}};
        fill_img(0); em = 0; run_frame(100, 100, 1);
        fill_img(0); em = 1; run_frame(100, 100, 1);
        fill_img(3); em = 0; run_frame(60, 30, 0);
        for (int i = 1; i < 3; i++) for (int j = i; j < 3; j++) cm[i][j] = int'($urandom_range(60));
        fill_img(3); em = 1; run_frame(70, 40, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
